// File: rtl/iq_issue_select_pkg.sv
// Shared types and helpers for the issue-queue select stage.
// iq_age_t and is_older() carry ROB indices widened to ROB_W_MAX bits so one
// definition serves any ROB_SIZE_LOG up to that width (zero-extension keeps order).
package iq_pkg;

    localparam int IQ_DEPTH_DEF     = 8;
    localparam int ROB_SIZE_LOG_DEF = 6;
    localparam int IQ_IDX_W         = $clog2(IQ_DEPTH_DEF);
    localparam int ROB_W_MAX        = 16;

    typedef struct packed {
        logic                 flag;
        logic [ROB_W_MAX-1:0] robidx;
    } iq_age_t;

    // A is older than B: same wrap flag compares directly, differing flags invert.
    function automatic logic is_older(input logic                 flagA,
                                      input logic [ROB_W_MAX-1:0] idxA,
                                      input logic                 flagB,
                                      input logic [ROB_W_MAX-1:0] idxB);
        if (flagA == flagB) begin
            return idxA < idxB;
        end
        return idxA > idxB;
    endfunction

endpackage

// File: rtl/iq_issue_select_if.sv
// Issue-register output handshake towards the execute-stage operand read.
// master = select stage (drives the instruction), slave = consumer (drives ready).
interface iq_issue_select_if #(
    parameter int IQ_DEPTH     = 8,
    parameter int ROB_SIZE_LOG = 6
);

    localparam int IDX_W = $clog2(IQ_DEPTH);

    logic                    out_valid;
    logic                    out_ready;
    logic [IDX_W-1:0]        out_idx;
    logic                    out_robidx_flag;
    logic [ROB_SIZE_LOG-1:0] out_robidx;

    modport master (
        output out_valid,
        output out_idx,
        output out_robidx_flag,
        output out_robidx,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_idx,
        input  out_robidx_flag,
        input  out_robidx,
        output out_ready
    );

endinterface

// File: rtl/iq_issue_select_age_pick.sv
// Combinational oldest-ready picker: a log2(IQ_DEPTH)-level tournament tree.
// Nodes are stored heap-style (node n has children 2n+1 / 2n+2, leaves at
// IQ_DEPTH-1+i), so the left child always covers the lower entry indices and
// keeping the left side on an age tie gives the lower-index-wins tie-break.
module iq_age_pick
    import iq_pkg::*;
#(
    parameter int IQ_DEPTH     = 8,
    parameter int ROB_SIZE_LOG = 6
) (
    input  logic [IQ_DEPTH-1:0]              ready_i,
    input  logic [IQ_DEPTH-1:0]              flag_i,
    input  logic [IQ_DEPTH*ROB_SIZE_LOG-1:0] robidx_i,
    output logic                             found_o,
    output logic [$clog2(IQ_DEPTH)-1:0]      winner_o
);

    localparam int IDX_W = $clog2(IQ_DEPTH);
    localparam int NODES = 2 * IQ_DEPTH - 1;

    logic [NODES-1:0] nodeFound;
    iq_age_t          nodeAge [NODES];
    logic [IDX_W-1:0] nodeIdx [NODES];

    // Fill the leaves from the entries, then reduce pairwise up to the root.
    always_comb begin
        logic takeRight;
        takeRight = 1'b0;
        nodeFound = '0;
        for (int n = 0; n < NODES; n++) begin
            nodeAge[n] = '0;
            nodeIdx[n] = '0;
        end
        for (int i = 0; i < IQ_DEPTH; i++) begin
            nodeFound[IQ_DEPTH-1+i]                             = ready_i[i];
            nodeAge[IQ_DEPTH-1+i].flag                          = flag_i[i];
            nodeAge[IQ_DEPTH-1+i].robidx[ROB_SIZE_LOG-1:0]      = robidx_i[i*ROB_SIZE_LOG +: ROB_SIZE_LOG];
            nodeIdx[IQ_DEPTH-1+i]                               = IDX_W'(i);
        end
        for (int n = IQ_DEPTH - 2; n >= 0; n--) begin
            takeRight = nodeFound[2*n+2] &
                        (~nodeFound[2*n+1] |
                         is_older(nodeAge[2*n+2].flag, nodeAge[2*n+2].robidx,
                                  nodeAge[2*n+1].flag, nodeAge[2*n+1].robidx));
            nodeFound[n] = nodeFound[2*n+1] | nodeFound[2*n+2];
            nodeAge[n]   = takeRight ? nodeAge[2*n+2] : nodeAge[2*n+1];
            nodeIdx[n]   = takeRight ? nodeIdx[2*n+2] : nodeIdx[2*n+1];
        end
    end

    assign found_o  = nodeFound[0];
    assign winner_o = nodeIdx[0];

endmodule

// File: rtl/iq_issue_select.sv
// Issue select for one issue queue: picks the oldest ready entry, pulses
// `issuing` back to it and loads a one-entry issue register that drives a
// valid/ready handshake to operand read.
// Optional build macro ISSUE_PERF_CNT_EN adds perf_issue_cnt / perf_stall_cnt.
module iq_issue_select
    import iq_pkg::*;
#(
    parameter int IQ_DEPTH     = 8,
    parameter int ROB_SIZE_LOG = 6
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             flush,
    input  logic [IQ_DEPTH-1:0]              entry_ready,
    input  logic [IQ_DEPTH-1:0]              entry_robidx_flag,
    input  logic [IQ_DEPTH*ROB_SIZE_LOG-1:0] entry_robidx,
    output logic [IQ_DEPTH-1:0]              issuing,
    output logic                             issue_fire,
    iq_issue_select_if.master                out_if
`ifdef ISSUE_PERF_CNT_EN
    ,
    output logic [63:0]                      perf_issue_cnt,
    output logic [63:0]                      perf_stall_cnt
`endif
);

    localparam int IDX_W = $clog2(IQ_DEPTH);

    logic                    found;
    logic [IDX_W-1:0]        winner;
    logic                    canAccept;
    logic                    selFire;

    logic                    outValid_q, outValid_d;
    logic [IDX_W-1:0]        outIdx_q, outIdx_d;
    logic                    outFlag_q, outFlag_d;
    logic [ROB_SIZE_LOG-1:0] outRob_q, outRob_d;

    iq_age_pick #(
        .IQ_DEPTH     (IQ_DEPTH),
        .ROB_SIZE_LOG (ROB_SIZE_LOG)
    ) u_age_pick (
        .ready_i  (entry_ready),
        .flag_i   (entry_robidx_flag),
        .robidx_i (entry_robidx),
        .found_o  (found),
        .winner_o (winner)
    );

    // Issue only when the register can take a new instruction and nothing is squashing this cycle.
    always_comb begin
        canAccept  = ~outValid_q | out_if.out_ready;
        selFire    = found & canAccept & ~flush & ~reset;
        issue_fire = selFire;
        issuing    = '0;
        if (selFire) begin
            issuing = {{(IQ_DEPTH-1){1'b0}}, 1'b1} << winner;
        end
    end

    // Issue register next state: flush drops the content, otherwise load/advance when the consumer allows.
    always_comb begin
        outValid_d = outValid_q;
        outIdx_d   = outIdx_q;
        outFlag_d  = outFlag_q;
        outRob_d   = outRob_q;
        if (flush) begin
            outValid_d = 1'b0;
        end else if (canAccept) begin
            outValid_d = found;
            if (found) begin
                outIdx_d  = winner;
                outFlag_d = entry_robidx_flag[winner];
                outRob_d  = entry_robidx[winner*ROB_SIZE_LOG +: ROB_SIZE_LOG];
            end
        end
    end

    // Issue register state; reset drops any held instruction.
    always_ff @(posedge clock) begin
        if (reset) begin
            outValid_q <= 1'b0;
            outIdx_q   <= '0;
            outFlag_q  <= 1'b0;
            outRob_q   <= '0;
        end else begin
            outValid_q <= outValid_d;
            outIdx_q   <= outIdx_d;
            outFlag_q  <= outFlag_d;
            outRob_q   <= outRob_d;
        end
    end

    assign out_if.out_valid       = outValid_q;
    assign out_if.out_idx         = outIdx_q;
    assign out_if.out_robidx_flag = outFlag_q;
    assign out_if.out_robidx      = outRob_q;

`ifdef ISSUE_PERF_CNT_EN
    logic [63:0] perfIssue_q;
    logic [63:0] perfStall_q;

    // Count issues and cycles where ready work is blocked by a full register; flush does not clear them.
    always_ff @(posedge clock) begin
        if (reset) begin
            perfIssue_q <= '0;
            perfStall_q <= '0;
        end else begin
            if (selFire) begin
                perfIssue_q <= perfIssue_q + 64'd1;
            end
            if ((|entry_ready) & ~canAccept & ~flush) begin
                perfStall_q <= perfStall_q + 64'd1;
            end
        end
    end

    assign perf_issue_cnt = perfIssue_q;
    assign perf_stall_cnt = perfStall_q;
`endif

endmodule

// File: tb/tb_iq_issue_select.sv
// Testbench for iq_issue_select. The driver applies one cycle of stimulus at a
// time, predicts the issue pick from a ROB-age reference (modular distance on
// {flag, idx}) and pushes it to a scoreboard queue; a separate monitor compares
// the issue register against the queue head whenever out_valid is high.
// Build with ISSUE_PERF_CNT_EN defined to also check the perf counters.
module tb_iq_issue_select;

    localparam int DEPTH = 8;
    localparam int RW    = 6;
    localparam int IW    = 3;
    localparam int WIN   = 1 << (RW + 1);

    typedef struct {
        int idx;
        bit flag;
        int rob;
    } exp_t;

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic                  flush = 1'b0;
    logic [DEPTH-1:0]      entryReady = '0;
    logic [DEPTH-1:0]      entryFlag = '0;
    logic [DEPTH*RW-1:0]   entryRob = '0;
    logic [DEPTH-1:0]      issuing;
    logic                  issueFire;
`ifdef ISSUE_PERF_CNT_EN
    logic [63:0]           perfIssue;
    logic [63:0]           perfStall;
`endif

    int         nCompared = 0;
    int         nMismatch = 0;
    exp_t       expQ[$];
    bit         mValid = 1'b0;
    longint     mIssue = 0;
    longint     mStall = 0;
    logic [7:0] dFlag;
    logic [47:0] dRob;

    iq_issue_select_if #(.IQ_DEPTH(DEPTH), .ROB_SIZE_LOG(RW)) outIf ();

    iq_issue_select #(
        .IQ_DEPTH     (DEPTH),
        .ROB_SIZE_LOG (RW)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .flush             (flush),
        .entry_ready       (entryReady),
        .entry_robidx_flag (entryFlag),
        .entry_robidx      (entryRob),
        .issuing           (issuing),
        .issue_fire        (issueFire),
        .out_if            (outIf)
`ifdef ISSUE_PERF_CNT_EN
        ,
        .perf_issue_cnt    (perfIssue),
        .perf_stall_cnt    (perfStall)
`endif
    );

    // Free-running clock, period 10.
    always #5 clock = ~clock;

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // A older than B when B lies 1..half-window ahead of A on the wrapped ROB ring.
    function automatic bit olderThan(input bit fa, input int ia, input bit fb, input int ib);
        int a;
        int b;
        int d;
        a = (fa ? (1 << RW) : 0) + ia;
        b = (fb ? (1 << RW) : 0) + ib;
        d = ((b - a) % WIN + WIN) % WIN;
        return (d > 0) && (d < (1 << RW));
    endfunction

    function automatic int oldestReady();
        int best;
        best = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (entryReady[i]) begin
                if (best < 0 ||
                    olderThan(entryFlag[i], int'(entryRob[i*RW +: RW]),
                              entryFlag[best], int'(entryRob[best*RW +: RW]))) begin
                    best = i;
                end
            end
        end
        return best;
    endfunction

    task automatic setEntry(input int i, input bit f, input int idx);
        dFlag[i]         = f;
        dRob[i*RW +: RW] = RW'(idx);
    endtask

    // Random ages within half a ROB window so the age order is total; a small span forces ties.
    task automatic randomAges();
        int base;
        int span;
        int age;
        base = int'($urandom_range(0, WIN - 1));
        span = ($urandom_range(0, 3) == 0) ? 2 : (1 << RW) - 1;
        for (int i = 0; i < DEPTH; i++) begin
            age = (base + int'($urandom_range(0, span))) % WIN;
            dFlag[i]         = age[RW];
            dRob[i*RW +: RW] = age[RW-1:0];
        end
    endtask

    // One cycle: check registered state, drive inputs, check the combinational pick, advance the model.
    task automatic applyStimulus(input bit r, input bit f, input bit oR,
                                 input logic [7:0] rdy, input logic [7:0] fl, input logic [47:0] rob);
        bit         canAcc;
        int         pick;
        logic [7:0] expIss;
        @(posedge clock);
        #2;
        checkVal("out_valid", 64'(outIf.out_valid), 64'(mValid));
`ifdef ISSUE_PERF_CNT_EN
        checkVal("perf_issue_cnt", perfIssue, 64'(mIssue));
        checkVal("perf_stall_cnt", perfStall, 64'(mStall));
`endif
        reset           = r;
        flush           = f;
        outIf.out_ready = oR;
        entryReady      = rdy;
        entryFlag       = fl;
        entryRob        = rob;
        #1;
        canAcc = !mValid || oR;
        pick   = oldestReady();
        expIss = '0;
        if (!r && !f && canAcc && pick >= 0) begin
            expIss[pick] = 1'b1;
        end
        checkVal("issuing", 64'(issuing), 64'(expIss));
        checkVal("issue_fire", 64'(issueFire), 64'(expIss != 0));
        if (r) begin
            mIssue = 0;
            mStall = 0;
        end else begin
            if (expIss != 0) mIssue++;
            if (rdy != 0 && !canAcc && !f) mStall++;
        end
        if (r || f) begin
            mValid = 1'b0;
            expQ.delete();
        end else if (canAcc) begin
            mValid = (pick >= 0);
            if (pick >= 0) begin
                expQ.push_back('{idx: pick, flag: entryFlag[pick], rob: int'(entryRob[pick*RW +: RW])});
            end
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checkVal("out_idx", 64'(outIf.out_idx), 64'(e.idx));
        checkVal("out_robidx_flag", 64'(outIf.out_robidx_flag), 64'(e.flag));
        checkVal("out_robidx", 64'(outIf.out_robidx), 64'(e.rob));
    endtask

    // Monitor: whenever the register presents an instruction, it must match the scoreboard head.
    initial begin
        forever begin
            @(negedge clock);
            if (outIf.out_valid === 1'b1 && !flush && !reset) begin
                if (expQ.size() == 0) begin
                    checkVal("unexpected_out_valid", 64'(outIf.out_valid), 64'd0);
                end else begin
                    checkOutput(expQ[0]);
                    if (outIf.out_ready) begin
                        void'(expQ.pop_front());
                    end
                end
            end
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        outIf.out_ready = 1'b0;
        dFlag = '0;
        dRob  = '0;

        $display("[TB] reset with all entries ready");
        randomAges();
        for (int c = 0; c < 3; c++) applyStimulus(1, 0, 1, 8'hFF, dFlag, dRob);
        for (int c = 0; c < 2; c++) applyStimulus(0, 0, 1, 8'h00, dFlag, dRob);

        $display("[TB] mixed ages and flags");
        dFlag = '0; dRob = '0;
        setEntry(2, 0, 5); setEntry(6, 0, 3); setEntry(7, 1, 1);
        applyStimulus(0, 0, 1, 8'hC4, dFlag, dRob);
        checkVal("t2_issuing", 64'(issuing), 64'h40);
        applyStimulus(0, 0, 1, 8'h00, dFlag, dRob);
        checkVal("t2_out_idx", 64'(outIf.out_idx), 64'd6);
        checkVal("t2_out_robidx", 64'(outIf.out_robidx), 64'd3);

        $display("[TB] ROB wrap");
        dFlag = '0; dRob = '0;
        setEntry(0, 1, 2); setEntry(1, 0, 60);
        applyStimulus(0, 0, 1, 8'h03, dFlag, dRob);
        checkVal("t3_issuing", 64'(issuing), 64'h02);
        applyStimulus(0, 0, 1, 8'h00, dFlag, dRob);

        $display("[TB] backpressure");
        randomAges();
        applyStimulus(0, 0, 0, 8'h5A, dFlag, dRob);
        for (int c = 0; c < 4; c++) begin
            randomAges();
            applyStimulus(0, 0, 0, 8'($urandom) | 8'h01, dFlag, dRob);
            checkVal("t4_hold_issuing", 64'(issuing), 64'd0);
        end
        randomAges();
        applyStimulus(0, 0, 1, 8'h81, dFlag, dRob);
        applyStimulus(0, 0, 1, 8'h00, dFlag, dRob);

        $display("[TB] flush while held");
        randomAges();
        applyStimulus(0, 0, 0, 8'h10, dFlag, dRob);
        applyStimulus(0, 1, 0, 8'h22, dFlag, dRob);
        checkVal("t5_flush_issuing", 64'(issuing), 64'd0);
        applyStimulus(0, 0, 0, 8'h00, dFlag, dRob);
        checkVal("t5_out_valid", 64'(outIf.out_valid), 64'd0);

        $display("[TB] perf counter scenario");
        for (int c = 0; c < 2; c++) applyStimulus(1, 0, 1, 8'h00, dFlag, dRob);
        for (int c = 0; c < 5; c++) begin
            randomAges();
            applyStimulus(0, 0, 1, 8'($urandom) | 8'h08, dFlag, dRob);
        end
        for (int c = 0; c < 3; c++) begin
            randomAges();
            applyStimulus(0, 0, 0, 8'($urandom) | 8'h04, dFlag, dRob);
        end
        applyStimulus(0, 0, 0, 8'h00, dFlag, dRob);
`ifdef ISSUE_PERF_CNT_EN
        checkVal("t6_perf_issue", perfIssue, 64'd5);
        checkVal("t6_perf_stall", perfStall, 64'd3);
`endif
        applyStimulus(0, 0, 1, 8'h00, dFlag, dRob);

        $display("[TB] random traffic");
        for (int c = 0; c < 800; c++) begin
            randomAges();
            applyStimulus($urandom_range(0, 99) == 0,
                          $urandom_range(0, 19) == 0,
                          $urandom_range(0, 9) < 7,
                          ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom) & 8'($urandom),
                          dFlag, dRob);
        end

        for (int c = 0; c < 3; c++) applyStimulus(0, 0, 1, 8'h00, dFlag, dRob);
        checkVal("drain_queue", 64'(expQ.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
